// File: rtl/reg_file_decoded.sv
// Register file with one write port and two registered read ports.
// The write index is decoded to one-hot per-register enables. Register 0 can
// optionally be hardwired to zero. A same-edge write can optionally be
// forwarded to the read ports. A clear command zeroes every register, one
// register per cycle.
module reg_file_decoded #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic              clr,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              rvalid,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_ok;
  logic              last;
  logic [DEPTH-1:0]  wr_vec;
  logic [DEPTH-1:0]  clr_vec;
  logic [DATA_W-1:0] val1, val2;

  // A write is taken only in IDLE. A same-edge clear wins over the write,
  // and writes to a hardwired-zero register 0 are discarded.
  assign wr_ok = (state == IDLE) && en && !clr && !((ZERO_REG != 0) && (rd == '0));
  assign last  = (cnt == ADDR_W'(DEPTH - 1));
  assign busy  = (state == CLEAR);

  // Next-state logic and clear counter advance.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (clr) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        if (last) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and clear counter.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with <= so every flop samples values
    // from before the edge, independent of the order of the statements.
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // One-hot decode of the write index and of the register being cleared.
  always_comb begin
    wr_vec  = '0;
    clr_vec = '0;
    if (wr_ok)           wr_vec[rd]   = 1'b1;
    if (state == CLEAR)  clr_vec[cnt] = 1'b1;
  end

  // Register storage; each entry listens only to its own decoded enables.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the array has an asynchronous reset because every register must
    // read 0 straight after reset; this forces flops rather than a RAM macro.
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr_vec[i])     regs[i] <= '0;
        else if (wr_ok && wr_vec[i]) regs[i] <= wdata;
      end
    end
  end

  // Value seen by a read port: zero register, then forwarded write, then storage.
  function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] idx);
    if ((ZERO_REG != 0) && (idx == '0))
      return '0;
    else if ((BYPASS != 0) && wr_ok && (rd == idx))
      return wdata;
    else
      return regs[idx];
  endfunction

  // Combinational read values for both ports.
  always_comb begin
    val1 = read_val(rs1);
    val2 = read_val(rs2);
  end

  // Registered read ports; data holds while no read is served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata1 <= '0;
      rdata2 <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= (state == IDLE) && re;
      if ((state == IDLE) && re) begin
        rdata1 <= val1;
        rdata2 <= val2;
      end
    end
  end

endmodule

// File: doc/reg_file_decoded.md
# reg_file_decoded

- Parametrised register file with one write port and two read ports.
- Write address `rd` is decoded internally to one-hot per-register write enables.
- Read ports `rs1`/`rs2` are registered, with optional write-to-read bypass, optional hardwired-zero register 0, and a sequenced clear-all command.
- Sits behind the instruction decode stage and supplies operands to the ALU.

## Interface
Parameters:
- `ADDR_W`, 5: register index width; `DEPTH` = 2**ADDR_W registers.
- `DATA_W`, 32: register data width.
- `ZERO_REG`, 1: 1 = register 0 reads 0 and ignores writes; 0 = register 0 is an ordinary register.
- `BYPASS`, 1: 1 = an accepted same-cycle write to a read index returns the new data; 0 = the read returns the old contents.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: write enable.
- `rd` in ADDR_W: write index.
- `wdata` in DATA_W: write data.
- `re` in 1: read request.
- `rs1` in ADDR_W: read index, port 1.
- `rs2` in ADDR_W: read index, port 2.
- `clr` in 1: clear-all request.
- `rdata1` out DATA_W: registered read data, port 1.
- `rdata2` out DATA_W: registered read data, port 2.
- `rvalid` out 1: `rdata1`/`rdata2` valid this cycle.
- `busy` out 1: clear sequence in progress.

## Operation
- States: IDLE, CLEAR.
- Reset (`rst_n`=0, asynchronous):
  - All DEPTH registers go to 0; `rdata1`, `rdata2`, `rvalid`, `busy` go to 0.
  - State goes to IDLE and the clear counter goes to 0.
- IDLE write: at a rising edge with `en`=1 and `clr`=0, `reg[rd]` <= `wdata`. The write is dropped when `ZERO_REG`=1 and `rd`=0.
- IDLE read: at a rising edge with `re`=1, `rdata1` <= value(`rs1`) and `rdata2` <= value(`rs2`), and `rvalid` <= 1.
- Value(x) is defined as:
  - 0 if `ZERO_REG`=1 and x=0;
  - otherwise `wdata` if `BYPASS`=1 and a write to x is accepted at the same edge;
  - otherwise the current `reg[x]`.
- `rvalid` is 1 for exactly one cycle per accepted `re`; otherwise 0. `rdata1`/`rdata2` hold their last values while `rvalid`=0.
- Clear command: `clr`=1 in IDLE moves the state to CLEAR at that edge and sets `busy` <= 1 and counter <= 0.
- Same-edge `en` and `clr`: the write is dropped (`clr` has priority). A same-edge `re` is still served from pre-clear contents with no bypass.
- CLEAR, each edge:
  - `reg[counter]` <= 0, then counter increments.
  - At the edge that clears index DEPTH-1, state returns to IDLE and `busy` <= 0.
- During CLEAR, `en`, `re` and `clr` are ignored: no writes, and `rvalid` stays 0.
- Counter width is ADDR_W. It is not used past DEPTH-1, so it never wraps.

## Timing
- Read latency is 1 cycle: `re` sampled at edge N gives `rdata*`/`rvalid` valid after edge N, for cycle N+1.
- Write latency is 1 cycle: data written at edge N is visible to a read sampled at edge N+1 regardless of `BYPASS`. At edge N it is visible only if `BYPASS`=1.
- `busy` is high for exactly DEPTH cycles, starting the cycle after the `clr` edge. The first new write or read is accepted at the edge where `busy` is seen low.
- Reset mid-CLEAR:
  - All outputs go to 0 immediately.
  - On `rst_n` release the block is in IDLE, with no residual clear and all registers 0.
- `rs1`=`rs2` is legal; both ports return the same value.

## Test plan
- Reset then read: assert `rst_n`=0 with registers previously loaded, release, then `re` with `rs1`=3, `rs2`=31 -> next cycle `rdata1`=0, `rdata2`=0, `rvalid`=1, then 0 the following cycle.
- Write/read back: write 0xDEADBEEF to rd=5 and 0x12345678 to rd=9, then `re` with `rs1`=5, `rs2`=9 -> `rdata1`=0xDEADBEEF, `rdata2`=0x12345678.
- Zero register: write 0xFFFFFFFF to rd=0, then read rs1=0 -> 0 with `ZERO_REG`=1, and 0xFFFFFFFF with `ZERO_REG`=0.
- Bypass: in one cycle, `en`=1, rd=7, `wdata`=0xA5A5A5A5, `re`=1, rs1=7, with reg[7] previously 0x11 -> `rdata1`=0xA5A5A5A5 with `BYPASS`=1, and 0x11 with `BYPASS`=0.
- Clear sequence: fill all 32 registers, pulse `clr` together with `en` to rd=4 -> the write is dropped, `busy` is high exactly 32 cycles, and `re` during busy gives no `rvalid`. After busy falls, reads of indices 1, 16 and 31 return 0.
- Reset mid-clear: assert `rst_n`=0 at the 10th busy cycle -> `busy`=0 at once; after release, `en` to rd=2 is accepted immediately and reads back correctly.
